// File: rtl/tick_gen_multi.sv
// tick_gen_multi: shared base-tick prescaler driving NUM_CH programmable tick channels
//   clock        : single clock, rising edge
//   reset        : synchronous, active-high
//   enable       : global run; low freezes the prescaler and every channel counter
//   ch_enable    : per-channel run; low clears that channel's counter, a rising edge re-arms it
//   ch_oneshot   : per-channel mode, 1 = one-shot, 0 = periodic
//   period_load  : per-channel strobe loading period_value (and re-arming when non-zero)
//   period_value : shared period data in base ticks, 0 = channel stopped
//   base_tick    : one-cycle pulse every BASE_US microseconds
//   ch_tick      : one-cycle pulse per channel expiry, coincident with base_tick
//   ch_busy      : channel armed and counting
module tick_gen_multi #(
   parameter int CLK_FREQ_HZ = 100_000_000,
   parameter int BASE_US     = 1000,
   parameter int NUM_CH      = 4,
   parameter int PERIOD_W    = 16,
   parameter int PERIOD_RST  = 100
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                enable,
   input  logic [NUM_CH-1:0]   ch_enable,
   input  logic [NUM_CH-1:0]   ch_oneshot,
   input  logic [NUM_CH-1:0]   period_load,
   input  logic [PERIOD_W-1:0] period_value,
   output logic                base_tick,
   output logic [NUM_CH-1:0]   ch_tick,
   output logic [NUM_CH-1:0]   ch_busy
);
   localparam int PRESCALE = (CLK_FREQ_HZ / 1_000_000) * BASE_US;
   localparam int PS_W = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
   localparam logic [PERIOD_W-1:0] P_RST = PERIOD_W'(PERIOD_RST);

   if (PRESCALE < 2) begin : g_bad_prescale
      $error("tick_gen_multi: PRESCALE must be at least 2");
   end

   logic [PS_W-1:0] ps_cnt;
   logic            base_ev;

   // Channels advance on the same combinational event that registers base_tick,
   // so every ch_tick lands in the same cycle as its base_tick.
   assign base_ev = enable && ps_cnt == PS_LAST;

   always_ff @(posedge clock) begin
      if (reset) begin
         ps_cnt    <= '0;
         base_tick <= 1'b0;
      end else begin
         base_tick <= base_ev;
         if (enable) ps_cnt <= base_ev ? '0 : ps_cnt + 1'b1;
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [PERIOD_W-1:0] period;
      logic [PERIOD_W-1:0] cnt;
      logic                busy;
      logic                tick;
      logic                en_q;
      logic                active;

      assign active     = ch_enable[i] && busy && period != '0;
      assign ch_tick[i] = tick;
      assign ch_busy[i] = busy;

      // Priority: load beats enable handling, which beats counting, so a load
      // landing on a terminal event swallows that tick.
      always_ff @(posedge clock) begin
         if (reset) begin
            period <= P_RST;
            cnt    <= '0;
            busy   <= P_RST != '0;
            tick   <= 1'b0;
            en_q   <= 1'b0;
         end else begin
            en_q <= ch_enable[i];
            tick <= 1'b0;
            if (period_load[i]) begin
               period <= period_value;
               cnt    <= '0;
               busy   <= period_value != '0;
            end else if (!ch_enable[i]) begin
               cnt <= '0;
            end else if (!en_q) begin
               cnt  <= '0;
               busy <= period != '0;
            end else if (base_ev && active) begin
               if (cnt == period - 1'b1) begin
                  cnt  <= '0;
                  tick <= 1'b1;
                  if (ch_oneshot[i]) busy <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
         end
      end
   end
endmodule

// File: doc/tick_gen_multi.md
TICK_GEN_MULTI -- requirements
Module: tick_gen_multi

Interface
REQ-001 The block SHALL have parameter CLK_FREQ_HZ, default 100_000_000, meaning the input clock frequency in Hz.
REQ-002 The block SHALL have parameter BASE_US, default 1000, meaning the base tick period in microseconds.
REQ-003 The block SHALL have parameter NUM_CH, default 4, meaning the number of independent tick channels.
REQ-004 The block SHALL have parameter PERIOD_W, default 16, meaning the channel period width in base ticks.
REQ-005 The block SHALL have parameter PERIOD_RST, default 100, meaning the reset period of every channel (100 ms at default base).
REQ-006 The block SHALL have port clock, input, 1 bit: the single clock, rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-008 The block SHALL have port enable, input, 1 bit: global run; when low, the prescaler freezes.
REQ-009 The block SHALL have port ch_enable, input, NUM_CH bits: per-channel run.
REQ-010 The block SHALL have port ch_oneshot, input, NUM_CH bits: per-channel mode, 1 = one-shot, 0 = periodic.
REQ-011 The block SHALL have port period_load, input, NUM_CH bits: per-channel load strobe.
REQ-012 The block SHALL have port period_value, input, PERIOD_W bits: shared period data, sampled on period_load.
REQ-013 The block SHALL have port base_tick, output, 1 bit: one-cycle pulse every BASE_US.
REQ-014 The block SHALL have port ch_tick, output, NUM_CH bits: one-cycle pulse per channel expiry.
REQ-015 The block SHALL have port ch_busy, output, NUM_CH bits: channel armed and counting.

Function
REQ-016 PRESCALE SHALL equal (CLK_FREQ_HZ/1_000_000)*BASE_US, and elaboration SHALL fail if PRESCALE < 2.
REQ-017 The prescaler counter, sized to $clog2(PRESCALE), SHALL count 0..PRESCALE-1 while enable=1, wrap to 0, and hold its value while enable=0.
REQ-018 base_tick SHALL be registered and high for exactly one cycle, in the cycle after the prescaler is at PRESCALE-1 with enable=1.
REQ-019 Each channel SHALL hold a PERIOD_W period register and a PERIOD_W counter advanced only by internal base-tick events.
REQ-020 Channel i SHALL count only when ch_enable[i]=1, ch_busy[i]=1 and period[i]!=0; a base event at counter=period[i]-1 SHALL clear the counter and pulse ch_tick[i] coincident with base_tick.
REQ-021 Tick spacing SHALL be exactly period[i]*PRESCALE clocks; period 1 SHALL tick on every base_tick.
REQ-022 Period 0 SHALL mean the channel is stopped: no ticks, counter held at 0, ch_busy[i]=0.
REQ-023 period_load[i] SHALL load period_value, clear counter i, and set ch_busy[i]=1 (if value != 0) in the next cycle.
REQ-024 When period_load[i] and a terminal event occur in the same cycle, the load SHALL win and no ch_tick[i] is emitted.
REQ-025 Multiple period_load bits asserted in one cycle SHALL all load the same period_value.
REQ-026 ch_enable[i]=0 SHALL clear counter i and force ch_tick[i]=0; a 0->1 edge of ch_enable[i] SHALL re-arm (ch_busy[i]=1) if period[i]!=0.
REQ-027 In periodic mode, the channel SHALL keep ch_busy=1 and repeat indefinitely.
REQ-028 In one-shot mode, the channel SHALL clear ch_busy[i] in the cycle of its ch_tick[i] and stay idle until re-armed by period_load[i] or a ch_enable[i] rising edge.
REQ-029 A change of ch_oneshot[i] mid-count SHALL take effect at the next terminal event only.
REQ-030 While enable=0, no base_tick or ch_tick SHALL occur, and channel counters SHALL hold their values (they are not cleared).

Reset
REQ-031 On reset, the prescaler and all channel counters SHALL be cleared to 0.
REQ-032 On reset, all periods SHALL be set to PERIOD_RST and ch_busy to all ones (if PERIOD_RST != 0).
REQ-033 On reset, base_tick and ch_tick SHALL be 0, and the internal ch_enable edge history SHALL be cleared.
REQ-034 Reset asserted mid-count SHALL take effect on the next edge, and any tick due that cycle SHALL be suppressed.

Verification (CLK_FREQ_HZ=10_000_000, BASE_US=1 -> PRESCALE=10, NUM_CH=2, PERIOD_RST=3)
REQ-035 Scenario: reset release, all enables high -> base_tick in cycles 10, 20, 30...; ch_tick[0] and ch_tick[1] in cycles 30, 60, 90.
REQ-036 Scenario: load period 1 on ch0 -> ch_tick[0] coincides with every base_tick; ch1 is unaffected.
REQ-037 Scenario: ch1 one-shot, period 2 -> exactly one ch_tick[1], 20 cycles after arming, and ch_busy[1] falls in the same cycle; a ch_enable[1] 0->1 edge re-arms it.
REQ-038 Scenario: enable low for 7 cycles mid-period -> no ticks, and the next ch_tick is delayed by exactly 7 cycles.
REQ-039 Scenario: period_load on a terminal cycle -> no tick; the next tick occurs period_value*10 cycles later.
REQ-040 Scenario: load period 0 -> ch_busy=0, and no ticks for 1000 cycles.
